mult_ctrl_unit: RTL and testbench

- Control-path FSM for the repeated-addition multiplier. Drives the multiplier datapath's register enables and mux selects, and consumes its B_zero status.
- Wraps the datapath in a val/rdy request/response handshake and handles the B==0 operand, which the datapath cannot detect by itself.
- Sits directly upstream of the datapath. Its outputs connect one-to-one to A_en, B_en, M_en, B_mux_sel and M_mux_sel.

---
 rtl/mult_ctrl_unit.sv | 122 ++++++++++++
 tb/tb_mult_ctrl_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_ctrl_unit.sv
// Control-path FSM for the repeated-addition multiplier.
// Sequences the datapath (load, iterate M<=M+A / B<=B-1, hold) and wraps it
// in a val/rdy request/response handshake. A zero B operand is detected at
// accept time, because the datapath can only report B==1 (B_zero).
module mult_ctrl_unit #(
  parameter int unsigned w = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_val,
  output logic         req_rdy,
  input  logic [w-1:0] operands_bits_B,
  output logic         resp_val,
  input  logic         resp_rdy,
  output logic         A_en,
  output logic         B_en,
  output logic         M_en,
  output logic         B_mux_sel,
  output logic         M_mux_sel,
  input  logic         B_zero,
  output logic         busy,
  output logic [w-1:0] op_cycles
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [w-1:0] ZERO_W = {w{1'b0}};
  localparam logic [w-1:0] ONE_W  = {{(w-1){1'b0}}, 1'b1};

  state_e       state_q, state_d;
  logic [w-1:0] op_cycles_q, op_cycles_d;

  logic req_rdy_s, resp_val_s, busy_s;
  logic a_en_s, b_en_s, m_en_s, b_sel_s, m_sel_s;

  // State and cycle-counter registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_cycles_q <= ZERO_W;
    end else begin
      state_q     <= state_d;
      op_cycles_q <= op_cycles_d;
    end
  end

  // Next-state, counter update and datapath control decode.
  always_comb begin
    state_d     = state_q;
    op_cycles_d = op_cycles_q;
    req_rdy_s   = 1'b0;
    resp_val_s  = 1'b0;
    busy_s      = 1'b0;
    a_en_s      = 1'b0;
    b_en_s      = 1'b0;
    m_en_s      = 1'b0;
    b_sel_s     = 1'b0;
    m_sel_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_rdy_s = 1'b1;
        if (req_val) begin
          // Load A and B, clear M; restart the cycle count.
          a_en_s      = 1'b1;
          b_en_s      = 1'b1;
          m_en_s      = 1'b1;
          op_cycles_d = ZERO_W;
          if (operands_bits_B == ZERO_W) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        busy_s      = 1'b1;
        b_en_s      = 1'b1;
        m_en_s      = 1'b1;
        b_sel_s     = 1'b1;
        m_sel_s     = 1'b1;
        op_cycles_d = op_cycles_q + ONE_W;
        // B_zero means the B register holds 1: this add is the last one.
        if (B_zero) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_DONE: begin
        busy_s     = 1'b1;
        resp_val_s = 1'b1;
        if (resp_rdy) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        op_cycles_d = op_cycles_q;
      end
    endcase
  end

  // Outputs are forced low for as long as reset is asserted.
  assign req_rdy   = rst_n & req_rdy_s;
  assign resp_val  = rst_n & resp_val_s;
  assign busy      = rst_n & busy_s;
  assign A_en      = rst_n & a_en_s;
  assign B_en      = rst_n & b_en_s;
  assign M_en      = rst_n & m_en_s;
  assign B_mux_sel = rst_n & b_sel_s;
  assign M_mux_sel = rst_n & m_sel_s;
  assign op_cycles = op_cycles_q;

endmodule

// File: tb/tb_mult_ctrl_unit.sv
// Testbench for mult_ctrl_unit: a behavioural datapath closes the loop, the
// driver pushes A*B expectations into a scoreboard queue at accept, and a
// monitor compares whenever a response is presented.
module tb_mult_ctrl_unit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_val;
  logic         req_rdy;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         resp_val;
  logic         resp_rdy;
  logic         a_en, b_en, m_en, b_sel, m_sel;
  logic         b_zero;
  logic         busy;
  logic [W-1:0] op_cycles;

  // Datapath registers (contents are don't-care until the first load).
  logic [W-1:0] dp_a = 16'd0;
  logic [W-1:0] dp_b = 16'd0;
  logic [W-1:0] dp_m = 16'd0;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] b;
    int           acc_cyc;
  } exp_t;

  exp_t q[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int stall_left = 0;
  bit rand_rdy   = 1'b0;

  mult_ctrl_unit #(.w(W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_val         (req_val),
    .req_rdy         (req_rdy),
    .operands_bits_B (op_b),
    .resp_val        (resp_val),
    .resp_rdy        (resp_rdy),
    .A_en            (a_en),
    .B_en            (b_en),
    .M_en            (m_en),
    .B_mux_sel       (b_sel),
    .M_mux_sel       (m_sel),
    .B_zero          (b_zero),
    .busy            (busy),
    .op_cycles       (op_cycles)
  );

  always #5 clk = ~clk;

  // Cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural repeated-addition datapath.
  always @(posedge clk) begin
    if (a_en) dp_a <= op_a;
    if (b_en) dp_b <= b_sel ? dp_b - 16'd1 : op_b;
    if (m_en) dp_m <= m_sel ? dp_m + dp_a : 16'd0;
  end
  assign b_zero = ((dp_b - 16'd1) == 16'd0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Consumer side: optional forced stall in DONE, otherwise ready or random.
  always @(posedge clk) begin
    #1;
    if (resp_val && stall_left > 0) begin
      resp_rdy = 1'b0;
      stall_left--;
    end else if (rand_rdy) begin
      resp_rdy = ($urandom_range(0, 3) != 0);
    end else begin
      resp_rdy = 1'b1;
    end
  end

  // Present a request and wait for its accept; the expectation is pushed then.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    bit   ok = 1'b0;
    int unsigned prod;
    op_a    = a;
    op_b    = b;
    req_val = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (req_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      prod      = int'(a) * int'(b);
      e.res     = prod[W-1:0];
      e.b       = b;
      e.acc_cyc = cyc;
      q.push_back(e);
    end else begin
      chk("accept_timeout", 32'd0, 32'd1);
    end
    @(posedge clk);
    #1;
    req_val = 1'b0;
  endtask

  // Monitor: protocol, control decode and scoreboard comparisons.
  bit           seen_resp = 1'b0;
  bit           idle_next = 1'b0;
  int           calc_cnt  = 0;
  logic [W-1:0] last_b    = 16'd0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      seen_resp = 1'b0;
      idle_next = 1'b0;
      last_b    = 16'd0;
      chk("reset_outputs", {req_rdy, resp_val, busy, a_en, b_en, m_en, b_sel, m_sel, op_cycles}, 32'd0);
    end else begin
      if (idle_next) begin
        chk("idle_after_handshake", {req_rdy, busy, resp_val}, 32'b100);
        idle_next = 1'b0;
      end
      if (!busy) begin
        chk("idle_op_cycles_held", op_cycles, last_b);
        if (req_val && req_rdy) begin
          chk("accept_ctrl", {a_en, b_en, m_en, b_sel, m_sel}, 32'b11100);
          calc_cnt = 0;
        end else begin
          chk("idle_ctrl", {req_rdy, a_en, b_en, m_en}, 32'b1000);
        end
      end else if (!resp_val) begin
        calc_cnt++;
        chk("calc_ctrl", {req_rdy, a_en, b_en, m_en, b_sel, m_sel}, 32'b001111);
      end
      if (resp_val) begin
        chk("done_ctrl", {req_rdy, busy, a_en, b_en, m_en}, 32'b01000);
        if (q.size() == 0) begin
          chk("unexpected_response", 32'd1, 32'd0);
        end else begin
          e = q[0];
          if (!seen_resp) begin
            seen_resp = 1'b1;
            chk("latency", cyc - e.acc_cyc, (e.b == 16'd0) ? 1 : int'(e.b) + 1);
            chk("calc_cycles", calc_cnt, int'(e.b));
          end
          chk("result", dp_m, e.res);
          chk("op_cycles", op_cycles, e.b);
          if (resp_rdy) begin
            last_b = e.b;
            void'(q.pop_front());
            seen_resp = 1'b0;
            idle_next = 1'b1;
          end
        end
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 3000 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) chk("drain_timeout", q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    req_val  = 1'b0;
    resp_rdy = 1'b1;
    op_a     = 16'd0;
    op_b     = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed operations.
    issue(16'd3, 16'd4);       drain();
    issue(16'd7, 16'd0);       drain();
    issue(16'd0, 16'd5);       drain();
    issue(16'd9, 16'd1);       drain();
    issue(16'hFFFF, 16'd2);    drain();

    // Backpressure with a second request held pending.
    stall_left = 4;
    issue(16'd5, 16'd3);
    issue(16'd2, 16'd2);
    drain();

    // Reset during the third CALC cycle.
    issue(16'd4, 16'd10);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_ctrl", {a_en, b_en, m_en, b_sel, m_sel, busy, req_rdy}, 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(16'd2, 16'd3);
    drain();

    // Randomized operations with random consumer backpressure.
    rand_rdy = 1'b1;
    for (int k = 0; k < 30; k++) begin
      issue(W'($urandom), W'($urandom_range(0, 12)));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    drain();
    rand_rdy = 1'b0;
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
